// File: rtl/rename_table.sv
// Register alias table with architectural register file and ROB-indexed result buffer.
// Answers two combinational operand lookups. Tracks renames, captures CDB results and
// retires committed values into the architectural file.
module rename_table #(
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      rd1_data,
  output logic [XLEN-1:0]      rd2_data,
  output logic                 rd1_ready,
  output logic                 rd2_ready,
  output logic [TAG_WIDTH-1:0] rd1_tag,
  output logic [TAG_WIDTH-1:0] rd2_tag,
  input  logic                 rename_valid,
  input  logic [4:0]           rename_rd,
  input  logic [TAG_WIDTH-1:0] rename_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [XLEN-1:0]      cdb_data,
  input  logic                 commit_valid,
  input  logic [4:0]           commit_rd,
  input  logic [XLEN-1:0]      commit_data,
  output logic [TAG_WIDTH-1:0] commit_ptr,
  output logic [NUM_REGS-1:0]  busy_vec
);

  localparam int unsigned RobSize = 2 ** TAG_WIDTH;

  typedef struct packed {
    logic                 ready;
    logic [XLEN-1:0]      data;
    logic [TAG_WIDTH-1:0] tag;
  } lookup_t;

  logic [XLEN-1:0]      arf       [NUM_REGS];
  logic [NUM_REGS-1:0]  busy;
  logic [TAG_WIDTH-1:0] rat_tag   [NUM_REGS];
  logic [RobSize-1:0]   res_valid;
  logic [XLEN-1:0]      res_data  [RobSize];

  lookup_t lk1, lk2;

  // Priority: x0, architectural value, buffered result, same-cycle CDB bypass, pending.
  function automatic lookup_t lookup(input logic [4:0] addr);
    lookup_t              r;
    logic [TAG_WIDTH-1:0] t;
    t       = rat_tag[addr];
    r.ready = 1'b0;
    r.data  = '0;
    r.tag   = t;
    if (addr == 5'd0) begin
      r.ready = 1'b1;
      r.tag   = '0;
    end else if (!busy[addr]) begin
      r.ready = 1'b1;
      r.data  = arf[addr];
      r.tag   = '0;
    end else if (res_valid[t]) begin
      r.ready = 1'b1;
      r.data  = res_data[t];
    end else if (cdb_valid && (cdb_tag == t)) begin
      r.ready = 1'b1;
      r.data  = cdb_data;
    end
    return r;
  endfunction

  // Combinational operand lookups on pre-edge state.
  always_comb begin
    lk1 = lookup(rs1_addr);
    lk2 = lookup(rs2_addr);
  end

  assign rd1_ready = lk1.ready;
  assign rd1_data  = lk1.data;
  assign rd1_tag   = lk1.tag;
  assign rd2_ready = lk2.ready;
  assign rd2_data  = lk2.data;
  assign rd2_tag   = lk2.tag;
  assign busy_vec  = busy;

  // Rename, CDB capture and commit updates; later assignments carry the priority rules.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        arf[i]     <= '0;
        rat_tag[i] <= '0;
      end
      for (int i = 0; i < RobSize; i++) begin
        res_data[i] <= '0;
      end
      busy       <= '0;
      res_valid  <= '0;
      commit_ptr <= '0;
    end else begin
      if (cdb_valid) begin
        res_valid[cdb_tag] <= 1'b1;
        res_data[cdb_tag]  <= cdb_data;
      end
      if (commit_valid) begin
        commit_ptr <= commit_ptr + TAG_WIDTH'(1);
        if (commit_rd != 5'd0) begin
          arf[commit_rd] <= commit_data;
        end
        // Only the youngest producer's retirement frees the register.
        if ((rat_tag[commit_rd] == commit_ptr) &&
            !(rename_valid && (rename_rd == commit_rd))) begin
          busy[commit_rd] <= 1'b0;
        end
      end
      // Rename comes last so its result-buffer clear beats a same-tag CDB write.
      if (rename_valid) begin
        res_valid[rename_tag] <= 1'b0;
        if (rename_rd != 5'd0) begin
          busy[rename_rd]    <= 1'b1;
          rat_tag[rename_rd] <= rename_tag;
        end
      end
    end
  end

endmodule
